// File: rtl/serial_arb_pkg.sv
// Shared definitions for the two-requester serialising arbiter:
// FSM state encoding and the default word length.
package serial_arb_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

endpackage : serial_arb_pkg

// File: rtl/serial_arb_ctrl_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last
// time is granted; a lone valid requester always wins.
module rr_arb2 (
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (valid0_i && valid1_i) begin
            grant_o = last_i ? 2'b01 : 2'b10;
        end else begin
            grant_o = {valid1_i, valid0_i};
        end
    end

endmodule : rr_arb2

// File: rtl/serial_arb_ctrl.sv
// Accepts a word from one of two requesters, shifts it out MSB first to a
// serial detector, counts detector hits and reports them once per word.
module serial_arb_ctrl
    import serial_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             ser_valid,
    output logic             ser_data,
    output logic             sel,
    input  logic             flag,
    output logic             done_valid,
    output logic             done_src,
    output logic [CW-1:0]    done_hits,
    output logic             busy
);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] shift_q;
    logic             sel_q;
    logic             last_q;
    logic [CW-1:0]    bit_cnt_q;
    logic [CW-1:0]    hit_cnt_q;
    logic [CW-1:0]    hit_cnt_d;
    logic             sample_q;
    logic             ser_valid_q;
    logic             ser_data_q;
    logic             done_valid_q;
    logic             done_src_q;
    logic [CW-1:0]    done_hits_q;

    logic [1:0]       grant;
    logic             in_idle;
    logic             accept;
    logic [WIDTH-1:0] accept_data;

    rr_arb2 u_arb (
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .last_i   (last_q),
        .grant_o  (grant)
    );

    // Readies are gated by rst_n so they drop the instant reset is asserted.
    assign in_idle     = rst_n && (state_q == ST_IDLE);
    assign req0_ready  = in_idle && grant[0];
    assign req1_ready  = in_idle && grant[1];
    assign accept      = req0_ready || req1_ready;
    assign accept_data = grant[1] ? req1_data : req0_data;

    // sample_q marks the cycle after a live bit: the only time flag counts.
    assign hit_cnt_d = hit_cnt_q + {{(CW-1){1'b0}}, (sample_q & flag)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            sel_q        <= 1'b0;
            last_q       <= 1'b1;
            bit_cnt_q    <= '0;
            hit_cnt_q    <= '0;
            sample_q     <= 1'b0;
            ser_valid_q  <= 1'b0;
            ser_data_q   <= 1'b0;
            done_valid_q <= 1'b0;
            done_src_q   <= 1'b0;
            done_hits_q  <= '0;
        end else begin
            sample_q     <= ser_valid_q;
            done_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shift_q     <= accept_data;
                        sel_q       <= grant[1];
                        last_q      <= grant[1];
                        hit_cnt_q   <= '0;
                        bit_cnt_q   <= '0;
                        ser_valid_q <= 1'b1;
                        ser_data_q  <= accept_data[WIDTH-1];
                        state_q     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    hit_cnt_q <= hit_cnt_d;
                    if (bit_cnt_q == LAST_BIT) begin
                        ser_valid_q <= 1'b0;
                        ser_data_q  <= 1'b0;
                        state_q     <= ST_DRAIN;
                    end else begin
                        shift_q    <= shift_q << 1;
                        ser_data_q <= shift_q[WIDTH-2];
                        bit_cnt_q  <= bit_cnt_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // The final flag sample is folded straight into the report.
                    hit_cnt_q    <= hit_cnt_d;
                    done_valid_q <= 1'b1;
                    done_src_q   <= sel_q;
                    done_hits_q  <= hit_cnt_d;
                    state_q      <= ST_REPORT;
                end
                ST_REPORT: begin
                    done_src_q  <= 1'b0;
                    done_hits_q <= '0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ser_valid  = ser_valid_q;
    assign ser_data   = ser_data_q;
    assign sel        = sel_q;
    assign done_valid = done_valid_q;
    assign done_src   = done_src_q;
    assign done_hits  = done_hits_q;
    assign busy       = (state_q != ST_IDLE);

endmodule : serial_arb_ctrl

// File: tb/tb_serial_arb_ctrl.sv
// Directed bench with a scoreboard: stimulus queues expected grants, words
// and reports; a negedge monitor pops and compares as the DUT produces them.
module tb_serial_arb_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0;
    logic [W-1:0]  req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [W-1:0]  req1_data = '0;
    logic          req1_ready;
    logic          ser_valid;
    logic          ser_data;
    logic          sel;
    logic          flag = 1'b0;
    logic          done_valid;
    logic          done_src;
    logic [CW-1:0] done_hits;
    logic          busy;

    serial_arb_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .ser_valid  (ser_valid),
        .ser_data   (ser_data),
        .sel        (sel),
        .flag       (flag),
        .done_valid (done_valid),
        .done_src   (done_src),
        .done_hits  (done_hits),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    int exp_acc_q[$];
    int exp_word_q[$];
    int exp_done_q[$];   // {src, hits} packed as src*256 + hits

    int acc_n = 0;
    int acc_cyc = -1000;
    int prev_acc = -1;
    int cur_src = 0;
    bit spacing_chk = 1'b0;
    bit collecting = 1'b0;
    int nbits = 0;
    int word = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            collecting = 1'b0;
            nbits      = 0;
            acc_cyc    = -1000;
            chk("reset_outputs", {req0_ready, req1_ready, ser_valid, ser_data, sel,
                                  done_valid, done_src, busy, 24'(done_hits)}, 0);
        end else begin
            if ((cyc - acc_cyc) >= 1 && (cyc - acc_cyc) <= W + 2) begin
                chk("busy_in_transfer", busy, 1);
                chk("ready_while_busy", req0_ready | req1_ready, 0);
            end else begin
                chk("busy_idle", busy, 0);
            end
            if ((req0_ready && req0_valid) || (req1_ready && req1_valid)) begin
                int src;
                src = req1_ready ? 1 : 0;
                chk("single_ready", req0_ready & req1_ready, 0);
                if (exp_acc_q.size() > 0) chk("grant_src", src, exp_acc_q.pop_front());
                else chk("unexpected_accept", 1, 0);
                if (spacing_chk && prev_acc >= 0) chk("accept_spacing", cyc - prev_acc, W + 3);
                prev_acc = cyc;
                acc_cyc  = cyc;
                cur_src  = src;
                acc_n++;
            end
            if (ser_valid) begin
                if (!collecting) begin
                    chk("first_bit_latency", cyc - acc_cyc, 1);
                    collecting = 1'b1;
                    word  = 0;
                    nbits = 0;
                end
                word = ((word << 1) | int'(ser_data)) & 'hFF;
                nbits++;
                chk("sel_during_transfer", sel, cur_src);
            end else begin
                chk("ser_data_when_idle", ser_data, 0);
                if (collecting) begin
                    collecting = 1'b0;
                    chk("bit_count", nbits, W);
                    if (exp_word_q.size() > 0) chk("serial_word", word, exp_word_q.pop_front());
                    else chk("unexpected_word", 1, 0);
                end
            end
            if (done_valid) begin
                chk("done_latency", cyc - acc_cyc, W + 2);
                if (exp_done_q.size() > 0) chk("done_src_hits", done_src * 256 + int'(done_hits),
                                               exp_done_q.pop_front());
                else chk("unexpected_done", 1, 0);
            end
        end
    end

    task automatic wait_acc(input int target, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (acc_n >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_timeout"}, acc_n, target);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Offsets are counted in cycles from the acceptance cycle; flag samples
    // land at offsets 2..W+1, so mask bits outside that range must be ignored.
    task automatic send_word(input int src, input logic [W-1:0] data,
                             input logic [15:0] mask, input int hits, input bit chg);
        exp_acc_q.push_back(src);
        exp_word_q.push_back(int'(data));
        exp_done_q.push_back(src * 256 + hits);
        @(posedge clk); #1;
        if (src == 0) begin req0_valid = 1'b1; req0_data = data; end
        else begin req1_valid = 1'b1; req1_data = data; end
        wait_acc(acc_n + 1, "send_accept");
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int o = 1; o <= 12; o++) begin
            flag = mask[o];
            if (chg && o == 3) begin req1_data = ~data; req0_data = ~data; end
            @(posedge clk); #1;
        end
        flag = 1'b0;
    endtask

    initial begin
        int rel_cyc;
        int start_n;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done_valid", done_valid, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Lone req0 with A5, no flags.
        send_word(0, 8'hA5, 16'h0000, 0, 1'b0);
        // Lone req1, flag after every bit.
        send_word(1, 8'h96, 16'h03FC, 8, 1'b0);
        // Flag only outside the sample windows.
        send_word(0, 8'h3C, 16'h1C02, 0, 1'b0);
        // Flags after first bit, fourth bit and the drain sample; data changed mid-transfer.
        send_word(1, 8'h71, 16'h0224, 3, 1'b1);

        // Reset during the 5th bit: interrupted word is dropped.
        exp_acc_q.push_back(0);
        @(posedge clk); #1;
        req0_valid = 1'b1;
        req0_data  = 8'h5A;
        wait_acc(acc_n + 1, "rst_accept");
        #1;
        req0_data = 8'h81;
        flag = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("async_reset_ser_valid", ser_valid, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_ready", req0_ready, 0);
        chk("async_reset_sel", sel, 0);
        flag = 1'b0;
        exp_acc_q.push_back(0);
        exp_word_q.push_back('h81);
        exp_done_q.push_back(0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rel_cyc = cyc;
        start_n = acc_n;
        wait_acc(start_n + 1, "post_reset_accept");
        chk("post_reset_accept_cycle", acc_cyc, rel_cyc);
        #1 req0_valid = 1'b0;
        repeat (12) @(posedge clk);

        // Both requesters valid continuously after a fresh reset.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exp_acc_q.push_back(k % 2);
            exp_word_q.push_back((k % 2 == 0) ? 'hFF : 'h00);
            exp_done_q.push_back((k % 2) * 256);
        end
        prev_acc    = -1;
        spacing_chk = 1'b1;
        start_n     = acc_n;
        req0_data   = 8'hFF;
        req1_data   = 8'h00;
        req0_valid  = 1'b1;
        req1_valid  = 1'b1;
        wait_acc(start_n + 4, "alternate_accept");
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (13) @(posedge clk);
        spacing_chk = 1'b0;

        chk("pending_grants", exp_acc_q.size(), 0);
        chk("pending_words", exp_word_q.size(), 0);
        chk("pending_reports", exp_done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_arb_ctrl

// File: doc/serial_arb_ctrl.md
SERIAL_ARB_CTRL -- requirements
Module: serial_arb_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the word length serialised per grant; legal range is 2..15.
REQ-002 The block SHALL have parameter CW, default $clog2(WIDTH+1), giving the hit-counter width.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port req0_valid  input  1  requester 0 has a word.
REQ-006 Port req0_data  input  WIDTH  requester 0 word.
REQ-007 Port req0_ready  output  1  requester 0 word accepted this cycle when high with req0_valid.
REQ-008 Ports req1_valid, req1_data, req1_ready: same as REQ-005..007 for requester 1.
REQ-009 Port ser_valid  output  1  ser_data carries a live bit to the serial detector.
REQ-010 Port ser_data  output  1  serial bit, MSB first.
REQ-011 Port sel  output  1  owner of the current word (0/1), stable for the whole transfer.
REQ-012 Port flag  input  1  detector hit, valid one cycle after the corresponding ser_valid bit.
REQ-013 Port done_valid  output  1  one-cycle report pulse.
REQ-014 Port done_src  output  1  owner of the reported word.
REQ-015 Port done_hits  output  CW  number of flag=1 samples for the reported word.
REQ-016 Port busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT, DRAIN, REPORT.
REQ-018 In IDLE, reqN_ready SHALL be high only for the granted requester, and only while its reqN_valid is high; both readies SHALL be low in all other states.
REQ-019 Grant SHALL be round-robin: with both valid, the requester not granted last wins; with one valid, it wins; last-grant pointer resets to 1 so requester 0 wins first tie.
REQ-020 On acceptance the block SHALL latch data into a shift register, latch sel, clear the hit counter and a bit counter, and enter SHIFT next cycle.
REQ-021 In SHIFT, ser_valid SHALL be high for exactly WIDTH consecutive cycles, presenting bits WIDTH-1 down to 0.
REQ-022 flag SHALL be sampled in the cycle after each ser_valid bit; the counter SHALL increment on each sample where flag=1; flag SHALL be ignored at all other times.
REQ-023 After the last bit the FSM SHALL enter DRAIN for one cycle (final flag sample), then REPORT for one cycle with done_valid=1, done_src=sel, done_hits=count.
REQ-024 From REPORT the FSM SHALL return to IDLE; a new word SHALL NOT be accepted before the IDLE cycle, giving minimum word spacing WIDTH+3 cycles.
REQ-025 Latency SHALL be: acceptance cycle T, first bit at T+1, last bit at T+WIDTH, done_valid at T+WIDTH+2.
REQ-026 done_hits SHALL not overflow (max WIDTH fits in CW bits); no saturation logic.
REQ-027 Changes of reqN_valid/reqN_data during a transfer SHALL have no effect on the transfer.
REQ-028 ser_data SHALL be 0 whenever ser_valid is 0.

Reset
REQ-029 Assertion of rst_n low SHALL immediately force IDLE, all outputs 0, counters 0, last-grant pointer 1, regardless of state.
REQ-030 A transfer interrupted by reset SHALL be discarded with no done_valid pulse; operation resumes in IDLE on the first edge after rst_n rises.

Structure
REQ-031 A shared package serial_arb_pkg SHALL hold the FSM state enum and the default WIDTH constant.
REQ-032 The round-robin grant logic SHALL be a sub-module rr_arb2 (inputs two valids plus pointer, output one-hot grant); the shift/count datapath stays in serial_arb_ctrl.

Verification
REQ-033 Reset then req0 word 8'hA5 alone -> ser_data 1,0,1,0,0,1,0,1 on 8 consecutive cycles, sel=0, done_valid at acceptance+10.
REQ-034 Both valid continuously with 8'hFF and 8'h00 -> grants alternate 0,1,0,1 from reset; accept spacing exactly 11 cycles.
REQ-035 flag driven 1 after every bit -> done_hits=8; flag=1 only outside the sample windows -> done_hits=0.
REQ-036 flag=1 after bits 0, 3 and the last bit (DRAIN sample) -> done_hits=3.
REQ-037 rst_n low during 5th bit -> all outputs 0 immediately, no done_valid, next req0 accepted on first IDLE cycle after release.
REQ-038 req1_data changed mid-transfer -> serial stream equals the value at acceptance.
